// File: rtl/lcd_timing_gen_pkg.sv
// rtl/lcd_timing_gen_pkg.sv - shared timing constants, axis state and coordinate types
package lcd_timing_pkg;

   localparam int unsigned CNT_W = 11;

   localparam int unsigned DEF_H_SYNC   = 48;
   localparam int unsigned DEF_H_BP     = 88;
   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FP     = 40;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BP     = 32;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 13;

   localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
   localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

   typedef enum logic [1:0] {SYNC_S, BP_S, ACT_S, FP_S} sync_state_t;

   typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/lcd_timing_gen_sync_axis_cnt.sv
// rtl/lcd_timing_gen_sync_axis_cnt.sv - one timing axis: position counter, region FSM, wrap
module sync_axis_cnt
   import lcd_timing_pkg::*;
#(
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic        wrap,
   output sync_state_t state,
   output coord_t      pos
);

   localparam int unsigned TOTAL = SYNC + BP + ACTIVE + FP;

   if (TOTAL > 2048 || SYNC == 0 || BP == 0 || ACTIVE == 0 || FP == 0) begin : g_bad_params
      $error("sync_axis_cnt: region widths must be nonzero and total at most 2048");
   end

   // Last position of each region; the FSM leaves a region when the counter sits on it.
   localparam coord_t LAST_SYNC = coord_t'(SYNC - 1);
   localparam coord_t LAST_BP   = coord_t'(SYNC + BP - 1);
   localparam coord_t LAST_ACT  = coord_t'(SYNC + BP + ACTIVE - 1);
   localparam coord_t LAST      = coord_t'(TOTAL - 1);

   sync_state_t r_state;
   sync_state_t w_next_state;
   coord_t      r_cnt;
   coord_t      w_next_cnt;
   logic        w_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SYNC_S;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_wrap       = 1'b0;
      if (adv) begin
         if (r_cnt == LAST) begin
            w_wrap     = 1'b1;
            w_next_cnt = '0;
         end else begin
            w_next_cnt = r_cnt + coord_t'(1);
         end
         unique case (r_state)
            SYNC_S: if (r_cnt == LAST_SYNC) w_next_state = BP_S;
            BP_S:   if (r_cnt == LAST_BP)   w_next_state = ACT_S;
            ACT_S:  if (r_cnt == LAST_ACT)  w_next_state = FP_S;
            FP_S:   if (w_wrap)             w_next_state = SYNC_S;
         endcase
      end
   end

   assign wrap  = w_wrap;
   assign state = r_state;
   assign pos   = r_cnt;

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - HS/VS/DE and active-area coordinates for the RGB LCD path
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0
) (
   input  logic   clk,
   input  logic   rst,
   output logic   out_hs,
   output logic   out_vs,
   output logic   out_de,
   output coord_t x_out,
   output coord_t y_out,
   output logic   frame_start
);

   localparam coord_t H_OFS = coord_t'(H_SYNC + H_BP);
   localparam coord_t V_OFS = coord_t'(V_SYNC + V_BP);

   logic        w_h_wrap;
   logic        w_v_wrap;
   sync_state_t w_h_state;
   sync_state_t w_v_state;
   coord_t      w_h_pos;
   coord_t      w_v_pos;
   logic        w_de;

   // True exactly when the counters hold (0,0): after reset or after a frame wrap.
   logic r_at_origin;

   logic   r_hs;
   logic   r_vs;
   logic   r_de;
   coord_t r_x;
   coord_t r_y;
   logic   r_fs;

   sync_axis_cnt #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)) u_h_axis (
      .clk   (clk),
      .rst   (rst),
      .adv   (1'b1),
      .wrap  (w_h_wrap),
      .state (w_h_state),
      .pos   (w_h_pos)
   );

   sync_axis_cnt #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)) u_v_axis (
      .clk   (clk),
      .rst   (rst),
      .adv   (w_h_wrap),
      .wrap  (w_v_wrap),
      .state (w_v_state),
      .pos   (w_v_pos)
   );

   assign w_de = (w_h_state == ACT_S) && (w_v_state == ACT_S);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_at_origin <= 1'b1;
         r_hs        <= ~HS_POL;
         r_vs        <= ~VS_POL;
         r_de        <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_fs        <= 1'b0;
      end else begin
         r_at_origin <= w_v_wrap;
         r_hs        <= (w_h_state == SYNC_S) ? HS_POL : ~HS_POL;
         r_vs        <= (w_v_state == SYNC_S) ? VS_POL : ~VS_POL;
         r_de        <= w_de;
         r_x         <= w_de ? (w_h_pos - H_OFS) : '0;
         r_y         <= w_de ? (w_v_pos - V_OFS) : '0;
         r_fs        <= r_at_origin;
      end
   end

   assign out_hs      = r_hs;
   assign out_vs      = r_vs;
   assign out_de      = r_de;
   assign x_out       = r_x;
   assign y_out       = r_y;
   assign frame_start = r_fs;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen with a reduced raster
module tb_lcd_timing_gen;

   localparam int HS_ = 4, HB = 5, HA = 10, HF = 3;
   localparam int VS_ = 2, VB = 3, VA = 6, VF = 2;
   localparam int HT = HS_ + HB + HA + HF;
   localparam int VT = VS_ + VB + VA + VF;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hs0, vs0, de0, fs0;
   logic        hs1, vs1, de1, fs1;
   logic [10:0] x0, y0, x1, y1;

   int n_checks = 0;
   int n_pass   = 0;

   // Model raster position that the next edge will decode, and expected outputs.
   int   mh = 0, mv = 0;
   logic e_hs_act, e_vs_act, e_de, e_fs;
   int   e_x, e_y;

   always #5 clk = ~clk;

   lcd_timing_gen #(
      .H_SYNC(HS_), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS_), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut0 (
      .clk(clk), .rst(rst), .out_hs(hs0), .out_vs(vs0), .out_de(de0),
      .x_out(x0), .y_out(y0), .frame_start(fs0)
   );

   lcd_timing_gen #(
      .H_SYNC(HS_), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
      .V_SYNC(VS_), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst), .out_hs(hs1), .out_vs(vs1), .out_de(de1),
      .x_out(x1), .y_out(y1), .frame_start(fs1)
   );

   task automatic step();
      if (rst) begin
         e_hs_act = 1'b0; e_vs_act = 1'b0; e_de = 1'b0; e_fs = 1'b0;
         e_x = 0; e_y = 0; mh = 0; mv = 0;
      end else begin
         e_hs_act = (mh < HS_);
         e_vs_act = (mv < VS_);
         e_de = (mh >= HS_ + HB) && (mh < HS_ + HB + HA) &&
                (mv >= VS_ + VB) && (mv < VS_ + VB + VA);
         e_x  = e_de ? mh - (HS_ + HB) : 0;
         e_y  = e_de ? mv - (VS_ + VB) : 0;
         e_fs = (mh == 0) && (mv == 0);
         mh = mh + 1;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1 == VT) ? 0 : mv + 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_fs(input string name);
      int k = 0;
      while (fs0 !== 1'b1 && k <= FRAME) begin
         step();
         k++;
      end
      n_checks++;
      if (fs0 === 1'b1) n_pass++;
      else $display("FAIL %s: frame_start not seen within %0d cycles", name, FRAME + 1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({hs0, vs0, de0, x0, y0, fs0, hs1, vs1} !== {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_hold: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b hs1=%b vs1=%b, want 1 1 0 0 0 0 0 0",
                  hs0, vs0, de0, x0, y0, fs0, hs1, vs1);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if ({hs0, vs0, fs0, de0, x0, y0, hs1, vs1} !== {1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1})
         $display("FAIL reset_release: got hs=%b vs=%b fs=%b de=%b x=%0d y=%0d hs1=%b vs1=%b, want 0 0 1 0 0 0 1 1",
                  hs0, vs0, fs0, de0, x0, y0, hs1, vs1);
      else n_pass++;
   endtask

   task automatic test_line_timing();
      int w, p, c, d;
      logic [10:0] lastx;
      rst = 1'b0;
      wait_fs("line_sync");
      w = 0;
      while (hs0 === 1'b0 && w <= HT) begin w++; step(); end
      p = w;
      while (hs0 === 1'b1 && p <= HT + 1) begin p++; step(); end
      n_checks++;
      if (w !== HS_) $display("FAIL hs_width: got %0d want %0d", w, HS_);
      else n_pass++;
      n_checks++;
      if (p !== HT) $display("FAIL line_period: got %0d want %0d", p, HT);
      else n_pass++;

      wait_fs("de_sync");
      c = 0;
      while (de0 !== 1'b1 && c < FRAME) begin step(); c++; end
      n_checks++;
      if (c !== (VS_ + VB) * HT + HS_ + HB || x0 !== 11'd0 || y0 !== 11'd0)
         $display("FAIL de_first: got offset=%0d x=%0d y=%0d want offset=%0d x=0 y=0",
                  c, x0, y0, (VS_ + VB) * HT + HS_ + HB);
      else n_pass++;
      d = 1;
      lastx = x0;
      step();
      while (de0 === 1'b1 && d <= HA) begin lastx = x0; d++; step(); end
      n_checks++;
      if (d !== HA || lastx !== 11'(HA - 1))
         $display("FAIL de_run: got len=%0d last_x=%0d want len=%0d last_x=%0d", d, lastx, HA, HA - 1);
      else n_pass++;
   endtask

   task automatic test_frame();
      int n_de = 0, n_vs = 0, n_extra = 0;
      logic [10:0] lx = '0, ly = '0;
      rst = 1'b0;
      wait_fs("frame_sync");
      for (int i = 0; i < FRAME; i++) begin
         if (de0 === 1'b1) begin n_de++; lx = x0; ly = y0; end
         if (vs0 === 1'b0) n_vs++;
         if (i > 0 && fs0 === 1'b1) n_extra++;
         step();
      end
      n_checks++;
      if (fs0 !== 1'b1 || n_extra != 0)
         $display("FAIL frame_period: got fs=%b extra=%0d after %0d cycles want fs=1 extra=0", fs0, n_extra, FRAME);
      else n_pass++;
      n_checks++;
      if (n_de != HA * VA) $display("FAIL de_count: got %0d want %0d", n_de, HA * VA);
      else n_pass++;
      n_checks++;
      if (n_vs != VS_ * HT) $display("FAIL vs_width: got %0d want %0d", n_vs, VS_ * HT);
      else n_pass++;
      n_checks++;
      if (lx !== 11'(HA - 1) || ly !== 11'(VA - 1))
         $display("FAIL last_de: got x=%0d y=%0d want x=%0d y=%0d", lx, ly, HA - 1, VA - 1);
      else n_pass++;
   endtask

   task automatic test_midframe_reset();
      int th, tv, k;
      for (int r = 0; r < 5; r++) begin
         th = (r == 0) ? HS_ + HB + 3 : $urandom_range(0, HT - 1);
         tv = (r == 0) ? VS_ + VB + 2 : $urandom_range(0, VT - 1);
         rst = 1'b0;
         k = 0;
         while (!(mh == th && mv == tv) && k <= FRAME) begin step(); k++; end
         rst = 1'b1;
         step();
         n_checks++;
         if ({hs0, vs0, de0, x0, y0, fs0} !== {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0})
            $display("FAIL midreset_hold(%0d,%0d): got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b want 1 1 0 0 0 0",
                     th, tv, hs0, vs0, de0, x0, y0, fs0);
         else n_pass++;
         rst = 1'b0;
         step();
         n_checks++;
         if ({fs0, hs0, vs0, de0} !== {1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL midreset_release(%0d,%0d): got fs=%b hs=%b vs=%b de=%b want 1 0 0 0",
                     th, tv, fs0, hs0, vs0, de0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int hold = 0;
      rst = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         if (hold > 0) hold--;
         else if ($urandom_range(0, 399) == 0) hold = $urandom_range(1, 3);
         rst = (hold > 0);
         step();
         n_checks++;
         if ({hs0, vs0, de0, x0, y0, fs0} !==
             {~e_hs_act, ~e_vs_act, e_de, 11'(e_x), 11'(e_y), e_fs} ||
             (32'(x0) + 32'(y0) > HA + VA - 2))
            $display("FAIL scoreboard cyc %0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b want %b %b %b %0d %0d %b",
                     i, hs0, vs0, de0, x0, y0, fs0, ~e_hs_act, ~e_vs_act, e_de, e_x, e_y, e_fs);
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_polarity();
      rst = 1'b0;
      for (int i = 0; i < FRAME + 7; i++) begin
         step();
         n_checks++;
         if ({hs1, vs1, de1, x1, y1, fs1} !== {e_hs_act, e_vs_act, e_de, 11'(e_x), 11'(e_y), e_fs})
            $display("FAIL polarity cyc %0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b want %b %b %b %0d %0d %b",
                     i, hs1, vs1, de1, x1, y1, fs1, e_hs_act, e_vs_act, e_de, e_x, e_y, e_fs);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame();
      test_midframe_reset();
      test_random();
      test_polarity();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Video timing generator for the 800x480 RGB LCD path. Produces HS/VS/DE and active-area pixel coordinates `x_out`/`y_out` from free-running horizontal and vertical counters. Sits directly upstream of the colour pattern / display stage, which consumes `hs`, `vs`, `de`, `x`, `y` and delays the syncs to match its own data latency.

## Interface

Parameters:

- `H_SYNC`, 48, HS pulse width (pixels)
- `H_BP`, 88, horizontal back porch
- `H_ACTIVE`, 800, active pixels per line
- `H_FP`, 40, horizontal front porch
- `V_SYNC`, 3, VS pulse width (lines)
- `V_BP`, 32, vertical back porch
- `V_ACTIVE`, 480, active lines
- `V_FP`, 13, vertical front porch
- `HS_POL`, 1'b0, active level of `out_hs`
- `VS_POL`, 1'b0, active level of `out_vs`

Ports:

- `clk` in 1 pixel clock
- `rst` in 1 reset; synchronous, active-high
- `out_hs` out 1 horizontal sync, level `HS_POL` when active
- `out_vs` out 1 vertical sync, level `VS_POL` when active
- `out_de` out 1 data enable; high in the active area only
- `x_out` out 11 active pixel column 0..H_ACTIVE-1; 0 when `out_de`=0
- `y_out` out 11 active line 0..V_ACTIVE-1; 0 when `out_de`=0
- `frame_start` out 1 one-cycle pulse coincident with outputs for counter (0,0)

## Operation

- Totals: H_TOTAL = 976 (H_SYNC+H_BP+H_ACTIVE+H_FP); V_TOTAL = 528.
- Counters are 11 bits, unsigned. Elaboration fails if either total exceeds 2048 or any parameter is 0.
- Horizontal counter `h_cnt` runs 0..H_TOTAL-1, then wraps to 0.
- Vertical counter `v_cnt` increments only on the `h_cnt` wrap (975->0). It runs 0..V_TOTAL-1 and wraps to 0 when it wraps together with `h_cnt` at (975,527).
- Horizontal FSM states: H_SYNC_S, H_BP_S, H_ACT_S, H_FP_S.
  - Regions: [0,48), [48,136), [136,936), [936,976).
  - Transitions occur when `h_cnt` reaches each region boundary; H_FP_S -> H_SYNC_S on wrap.
- Vertical FSM uses the same four states on `v_cnt`.
  - Regions: [0,3), [3,35), [35,515), [515,528).
  - It advances only on the horizontal wrap.
- Decode:
  - hs active while H state = H_SYNC_S.
  - vs active while V state = V_SYNC_S, for whole lines.
  - de = (H state = H_ACT_S) && (V state = V_ACT_S).
  - x = h_cnt-136 and y = v_cnt-35 when de, else 0.
- All outputs are registered from the decode of the current counter value.

## Timing

- Reset (`rst`=1 at an edge) forces:
  - h_cnt = 0, v_cnt = 0, both FSMs to SYNC_S;
  - `out_hs` = ~HS_POL, `out_vs` = ~VS_POL;
  - `out_de`, `x_out`, `y_out`, `frame_start` = 0.
- First edge with `rst`=0: outputs show the decode of (0,0), so `out_hs`=HS_POL, `out_vs`=VS_POL and `frame_start`=1. The counter advances to (1,0) on the same edge.
- Latency: outputs lag the counter by exactly 1 clock. `x_out`/`y_out`/`out_de`/syncs are mutually aligned; no skew between them is allowed.
- `rst` asserted mid-line or mid-frame: the next edge restores reset values exactly. No partial line is completed.
- Frame period is exactly 976*528 = 515328 clocks between `frame_start` pulses. Line period is exactly 976 clocks between `out_hs` leading edges.
- Wrap boundary (975,527)->(0,0) produces no extra or missing cycle.

## Structure

- Package `lcd_timing_pkg` holds:
  - default timing constants and derived H_TOTAL/V_TOTAL;
  - `sync_state_t` enum {SYNC_S, BP_S, ACT_S, FP_S};
  - an 11-bit coordinate typedef shared with the display stage.
- Sub-module `sync_axis_cnt` implements one counter plus FSM plus region decode. It is parameterised by sync/bp/active/fp, has an `adv` input and outputs `wrap`, `state`, `pos`. It is instanced twice: H with `adv`=1; V with `adv` = H `wrap`.

## Test plan

- Reset release: after 3 cycles of `rst`=1 then release, the first output cycle gives `out_hs`=0, `out_vs`=0, `frame_start`=1, `out_de`=0, `x_out`=`y_out`=0.
- Line timing: `out_hs` low for exactly 48 clocks. `out_de` rises 136 clocks after the `out_hs` leading edge on line 35, with `x_out`=0 and `y_out`=0; `x_out` reaches 799 and `out_de` falls the next clock.
- Frame timing: `out_vs` low for exactly 3*976=2928 clocks. `frame_start` repeats every 515328 clocks. Exactly 480*800=384000 `out_de`-high cycles per frame, and the last one has `x_out`=799, `y_out`=479.
- Coordinate check: a scoreboard recomputes x/y from its own counters. Every `out_de` cycle matches, `x_out`+`y_out` never exceeds 1278, and x/y are 0 outside de.
- Mid-frame reset: `rst` pulsed for 1 cycle at counter (500,200) gives reset values next edge, then `frame_start` on the following edge.
- Polarity: a build with HS_POL=VS_POL=1 yields inverted syncs with identical widths and positions.
